// File: rtl/ascon_pkg.sv
// Shared types for the ASCON core arbiter: FSM state encoding and operation mode codes.
// mode_is_reserved() flags any mode the core cannot execute (1x codes).
package ascon_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } arb_state_e;

    localparam logic [1:0] MODE_ENC = 2'b00;
    localparam logic [1:0] MODE_DEC = 2'b01;

    function automatic logic mode_is_reserved(input logic [1:0] mode);
        return !((mode == MODE_ENC) || (mode == MODE_DEC));
    endfunction

endpackage

// File: rtl/ascon_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1 with wrap.
// Zero latency; pick_idx is don't-care (0) when any_valid is low.
module ascon_rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_valid,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate down so the nearest one after last_grant wins.
    always_comb begin
        any_valid = |req;
        pick_idx  = '0;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_idx = cand;
            end
        end
    end

endmodule

// File: rtl/ascon_arbiter.sv
// Round-robin sharing of one ASCON core among NUM_REQ requesters; ready at +1, core_start at +2, rsp 1 cycle after armed done.
// One op in flight, losers simply wait; optional WAIT watchdog under ASCON_ARB_TIMEOUT_EN.
module ascon_arbiter
    import ascon_pkg::*;
#(
    parameter  int NUM_REQ        = 2,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][1:0] req_mode,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic                    rsp_error,
    output logic                    core_start,
    output logic [1:0]              core_mode,
    input  logic                    core_done,
    input  logic                    core_error,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy,
    output logic                    timeout_flag
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [1:0]         mode_q, mode_d;
    logic               armed_q, armed_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] rvld_q, rvld_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic [1:0]         cmode_q, cmode_d;
    logic               busy_q, busy_d;

    logic               any_valid;
    logic [IDX_W-1:0]   pick_idx;

`ifdef ASCON_ARB_TIMEOUT_EN
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tflag_q, tflag_d;
`endif

    ascon_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req       (req_valid),
        .last_grant(last_q),
        .any_valid (any_valid),
        .pick_idx  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        mode_d  = mode_q;
        armed_d = armed_q;
        ready_d = '0;
        rvld_d  = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        cmode_d = 2'b00;
`ifdef ASCON_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tflag_d = tflag_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d           = GRANT;
                    grant_d           = pick_idx;
                    mode_d            = req_mode[pick_idx];
                    ready_d[pick_idx] = 1'b1;
                end
            end
            GRANT: begin
                if (mode_is_reserved(mode_q)) begin
                    state_d         = RESP;
                    rvld_d[grant_q] = 1'b1;
                    err_d           = 1'b1;
                end else begin
                    state_d = START;
                    start_d = 1'b1;
                    cmode_d = mode_q;
                end
            end
            START: begin
                state_d = WAIT;
                armed_d = 1'b0;
`ifdef ASCON_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // Only a done seen after a low sample belongs to this operation.
                if (!core_done) begin
                    armed_d = 1'b1;
                end
                if (armed_q && core_done) begin
                    state_d         = RESP;
                    rvld_d[grant_q] = 1'b1;
                    err_d           = core_error;
                end
`ifdef ASCON_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d         = RESP;
                    rvld_d[grant_q] = 1'b1;
                    err_d           = 1'b1;
                    tflag_d         = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            mode_q  <= MODE_ENC;
            armed_q <= 1'b0;
            ready_q <= '0;
            rvld_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            cmode_q <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            armed_q <= armed_d;
            ready_q <= ready_d;
            rvld_q  <= rvld_d;
            err_q   <= err_d;
            start_q <= start_d;
            cmode_q <= cmode_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ASCON_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tflag_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tflag_q <= tflag_d;
        end
    end

    assign timeout_flag = tflag_q;
`else
    // Watchdog compiled out: the flag is constant 0 for any legal TIMEOUT_CYCLES.
    assign timeout_flag = (TIMEOUT_CYCLES < 0);
`endif

    assign req_ready  = ready_q;
    assign rsp_valid  = rvld_q;
    assign rsp_error  = err_q;
    assign core_start = start_q;
    assign core_mode  = cmode_q;
    assign grant_idx  = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ascon_arbiter.sv
// Directed plus randomized checks of ascon_arbiter against a transaction-level round-robin/timing model.
module tb_ascon_arbiter;
    import ascon_pkg::*;

    localparam int NR = 3;
    localparam int IW = 2;
    localparam int T  = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0][1:0] req_mode;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      rsp_valid;
    logic               rsp_error;
    logic               core_start;
    logic [1:0]         core_mode;
    logic               core_done;
    logic               core_error;
    logic [IW-1:0]      grant_idx;
    logic               busy;
    logic               timeout_flag;

    int   compared   = 0;
    int   mismatched = 0;
    int   last_m     = NR - 1;
    logic tflag_exp  = 1'b0;

    always #5 clk = ~clk;

    ascon_arbiter #(
        .NUM_REQ       (NR),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_error   (rsp_error),
        .core_start  (core_start),
        .core_mode   (core_mode),
        .core_done   (core_done),
        .core_error  (core_error),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_flag(timeout_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting index after the last served one, wrapping.
    function automatic int model_pick(input logic [NR-1:0] v);
        for (int i = 1; i <= NR; i++) begin
            if (v[IW'((last_m + i) % NR)]) return (last_m + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int w);
        return NR'(1) << w;
    endfunction

    // One operation, started at a negedge in IDLE with req_valid/req_mode already driven.
    // Core done is high for the first hi0 edges after START, low for lo edges, then high.
    task automatic run_op(input int hi0, input int lo, input logic cerr, input logic drop);
        int       w;
        logic [1:0] m;
        logic     seen_low, accept, to, got, dv;
        w = model_pick(req_valid);
        m = req_mode[IW'(w)];
        @(negedge clk);
        chk("req_ready", req_ready, onehot(w));
        chk("grant_at_ready", grant_idx, w);
        chk("busy_grant", busy, 1);
        if (drop) req_valid = req_valid & ~onehot(w);
        @(negedge clk);
        if (m[1]) begin
            chk("rsv_no_start", core_start, 0);
            chk("rsv_rsp_valid", rsp_valid, onehot(w));
            chk("rsv_rsp_error", rsp_error, 1);
        end else begin
            chk("core_start", core_start, 1);
            chk("core_mode", core_mode, m);
            seen_low   = 1'b0;
            got        = 1'b0;
            core_error = cerr;
            for (int c = 0; c < 60 && !got; c++) begin
                dv        = !((c >= hi0) && (c < hi0 + lo));
                core_done = dv;
                accept    = (c >= 1) && seen_low && dv;
                to        = 1'b0;
`ifdef ASCON_ARB_TIMEOUT_EN
                to        = !accept && (c == T);
`endif
                if (c >= 1 && !dv) seen_low = 1'b1;
                @(negedge clk);
                chk("rsp_valid", rsp_valid, (accept || to) ? onehot(w) : '0);
                chk("grant_stable", grant_idx, w);
                chk("single_start", core_start, 0);
                if (accept || to) begin
                    chk("rsp_error", rsp_error, to ? 1'b1 : cerr);
                    if (to) tflag_exp = 1'b1;
                    got = 1'b1;
                end
            end
            chk("rsp_seen", got, 1);
            core_error = 1'b0;
        end
        chk("timeout_flag", timeout_flag, tflag_exp);
        @(negedge clk);
        chk("rsp_clear", rsp_valid, 0);
        chk("busy_idle", busy, 0);
        last_m = w;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_error"}, rsp_error, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_mode"}, core_mode, 0);
        chk({tag, "_grant_idx"}, grant_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout_flag, 0);
    endtask

    initial begin
        logic [NR-1:0] pend;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_mode   = '0;
        core_done  = 1'b0;
        core_error = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Contention from reset: 0,1,0,1
        req_valid   = 3'b011;
        req_mode[0] = MODE_ENC;
        req_mode[1] = MODE_DEC;
        for (int k = 0; k < 4; k++) run_op(0, 2 + k, 1'b0, 1'b0);

        // Single encrypt, done raised 10 cycles after dropping
        req_valid   = 3'b001;
        req_mode[0] = MODE_ENC;
        run_op(0, 10, 1'b0, 1'b1);

        // Reserved mode
        req_valid   = 3'b010;
        req_mode[1] = 2'b10;
        run_op(0, 2, 1'b0, 1'b1);

        // Stale done held high through START
        core_done   = 1'b1;
        req_valid   = 3'b001;
        req_mode[0] = MODE_DEC;
        run_op(4, 5, 1'b0, 1'b1);

        // Core error with the armed done
        req_valid   = 3'b100;
        req_mode[2] = MODE_ENC;
        run_op(0, 3, 1'b1, 1'b1);

        // Randomized traffic; pending requesters keep their request and mode
        for (int n = 0; n < 20; n++) begin
            pend = req_valid;
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) req_mode[i] = 2'($urandom_range(0, 3));
            end
            req_valid = pend | NR'($urandom_range(0, 7));
            if (req_valid == '0) req_valid[$urandom_range(0, NR - 1)] = 1'b1;
            run_op($urandom_range(0, 3), $urandom_range(2, 5), 1'($urandom_range(0, 1)), 1'b1);
        end
        req_valid = '0;
        @(negedge clk);

`ifdef ASCON_ARB_TIMEOUT_EN
        // Done arriving on the expiry edge wins, then a core that never finishes
        req_valid   = 3'b001;
        req_mode[0] = MODE_ENC;
        run_op(0, T, 1'b0, 1'b1);
        req_valid   = 3'b010;
        req_mode[1] = MODE_DEC;
        run_op(0, 1000, 1'b0, 1'b1);
`endif

        // Reset in the middle of WAIT
        req_valid   = 3'b100;
        req_mode[2] = MODE_DEC;
        core_done   = 1'b0;
        @(negedge clk);
        chk("rst_test_ready", req_ready, onehot(model_pick(3'b100)));
        req_valid = '0;
        @(negedge clk);
        chk("rst_test_start", core_start, 1);
        repeat (3) @(negedge clk);
        chk("rst_test_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n     = 1'b1;
        last_m    = NR - 1;
        tflag_exp = 1'b0;
        @(negedge clk);

        // Pointer restarts from NUM_REQ-1 after reset
        req_valid   = 3'b110;
        req_mode[1] = MODE_ENC;
        req_mode[2] = MODE_ENC;
        run_op(0, 3, 1'b0, 1'b1);
        run_op(0, 2, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
